fifo_rd_arbiter: RTL and testbench

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

---
 rtl/fifo_rd_arbiter_pkg.sv | 21 ++
 rtl/fifo_rd_skid_buf.sv | 63 ++++++
 rtl/fifo_rd_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared FIFO-read definitions: data word type, arbiter FSM states and the
// burst-length clamp used when a grant is taken.
package fifo_rd_arbiter_pkg;

  localparam int W_DATA = 16;

  typedef logic [W_DATA-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

  // A programmed length of zero, or one above the hardware maximum, means
  // "use the maximum".
  function automatic int eff_burst_len(input int cfg, input int max_len);
    return (cfg == 0 || cfg > max_len) ? max_len : cfg;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry output buffer holding popped words (with their source tag) in
// arrival order until the downstream accepts them.
module fifo_rd_skid_buf
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int SRC_W = 2
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             push,
  input  data_t            push_data,
  input  logic [SRC_W-1:0] push_src,
  input  logic             pop,
  output logic             valid,
  output data_t            data,
  output logic [SRC_W-1:0] src,
  output logic [1:0]       occupancy
);

  data_t            mem_data [2];
  logic [SRC_W-1:0] mem_src  [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_pop;

  assign do_pop = pop && (count != 2'd0);

  // Write on push, advance the read pointer on accept, track occupancy.
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this storage is reset, unlike a normal RAM, because it drives
      // m_data/m_src directly and those must read zero while in reset.
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_src[i]  <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_src[wr_ptr]  <= push_src;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid     = (count != 2'd0);
  assign data      = mem_data[rd_ptr];
  assign src       = mem_src[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter over N_SRC async-FIFO read ports. Pops are
// credit-limited so the two-entry output buffer never overflows, giving one
// word per cycle when the downstream is always ready.
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int BURST_MAX = 8
) (
  input  logic                           rd_clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [$clog2(BURST_MAX+1)-1:0] cfg_burst_len,
  input  logic [N_SRC-1:0]               src_empty,
  output logic [N_SRC-1:0]               src_pop,
  input  logic [N_SRC*W_DATA-1:0]        src_data,
  output data_t                          m_data,
  output logic [$clog2(N_SRC)-1:0]       m_src,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           burst_done
);

  localparam int LEN_W = $clog2(BURST_MAX + 1);
  localparam int SRC_W = $clog2(N_SRC);

  rd_state_t        state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] next_grant;
  logic             next_found;
  int               search_idx;
  logic [LEN_W-1:0] burst_len;
  logic [LEN_W-1:0] count;
  logic             inflight;
  logic [SRC_W-1:0] inflight_src;
  logic [1:0]       occupancy;
  logic             xfer;
  logic             credit_ok;
  logic             pop_now;
  data_t            capture_data;

  // Find the first non-empty source searching upward from rr_ptr (wrapping).
  always_comb begin
    next_grant = rr_ptr;
    next_found = 1'b0;
    search_idx = 0;
    for (int i = 0; i < N_SRC; i++) begin
      search_idx = (int'(rr_ptr) + i) % N_SRC;
      if (!next_found && !src_empty[search_idx]) begin
        next_found = 1'b1;
        next_grant = SRC_W'(search_idx);
      end
    end
  end

  // A pop is allowed only when the word it produces is sure to have a slot.
  assign xfer      = m_valid && m_ready;
  assign credit_ok = ({1'b0, occupancy} + {2'b00, inflight}) < (3'd2 + {2'b00, xfer});
  assign pop_now   = (state == BURST) && enable && !src_empty[grant] && credit_ok;

  // One-hot pop toward the granted source only.
  always_comb begin
    src_pop        = '0;
    src_pop[grant] = pop_now;
  end

  assign capture_data = src_data[int'(inflight_src)*W_DATA +: W_DATA];

  // Arbiter FSM: grant in IDLE, pop in BURST, close the burst in FLUSH.
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      burst_len    <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      inflight_src <= '0;
      burst_done   <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      inflight   <= pop_now;
      if (pop_now) begin
        inflight_src <= grant;
      end
      case (state)
        IDLE: begin
          if (enable && next_found) begin
            grant     <= next_grant;
            burst_len <= LEN_W'(eff_burst_len(32'(cfg_burst_len), BURST_MAX));
            count     <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (!enable || src_empty[grant]) begin
            state <= FLUSH;
          end else if (pop_now) begin
            count <= count + 1'b1;
            if (count + 1'b1 == burst_len) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // The only word that can still be in flight here is the one popped
          // on the last BURST cycle; it is captured on this same edge.
          state      <= IDLE;
          burst_done <= 1'b1;
          rr_ptr     <= (int'(grant) == N_SRC - 1) ? '0 : grant + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_rd_skid_buf #(
    .SRC_W (SRC_W)
  ) u_buf (
    .rd_clk    (rd_clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (capture_data),
    .push_src  (inflight_src),
    .pop       (m_ready),
    .valid     (m_valid),
    .data      (m_data),
    .src       (m_src),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed and randomized bench for fifo_rd_arbiter with behavioural source
// FIFOs and an output monitor.
module tb_fifo_rd_arbiter;
  import fifo_rd_arbiter_pkg::*;

  localparam int N_SRC     = 4;
  localparam int BURST_MAX = 8;
  localparam int LEN_W     = $clog2(BURST_MAX + 1);
  localparam int SRC_W     = $clog2(N_SRC);

  logic                    rd_clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    enable = 1'b0;
  logic                    m_ready = 1'b0;
  logic [LEN_W-1:0]        cfg_burst_len = LEN_W'(4);
  logic [N_SRC-1:0]        src_empty = '1;
  logic [N_SRC-1:0]        src_pop;
  logic [N_SRC*W_DATA-1:0] src_data;
  data_t                   m_data;
  logic [SRC_W-1:0]        m_src;
  logic                    m_valid;
  logic                    burst_done;

  int errors = 0;
  int checks = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_arbiter #(
    .N_SRC     (N_SRC),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .rd_clk        (rd_clk),
    .reset         (reset),
    .enable        (enable),
    .cfg_burst_len (cfg_burst_len),
    .src_empty     (src_empty),
    .src_pop       (src_pop),
    .src_data      (src_data),
    .m_data        (m_data),
    .m_src         (m_src),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .burst_done    (burst_done)
  );

  // Behavioural source FIFOs: data appears one cycle after a pop.
  data_t            src_q [N_SRC][$];
  data_t            src_word [N_SRC] = '{default: '0};
  logic [N_SRC-1:0] pop_s = '0;
  int               underflows = 0;

  for (genvar g = 0; g < N_SRC; g++) begin : g_data
    assign src_data[g*W_DATA +: W_DATA] = src_word[g];
  end

  always @(posedge rd_clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (pop_s[i]) begin
        if (src_q[i].size() == 0) underflows++;
        else src_word[i] <= src_q[i].pop_front();
      end
      src_empty[i] <= (src_q[i].size() == 0);
    end
  end

  // Output monitor, sampled on the falling edge.
  logic [SRC_W-1:0] obs_src [$];
  data_t            obs_data [$];
  int               obs_cyc [$];
  int               cyc = 0;
  int               multi_pop = 0;
  int               bd_count = 0;

  always @(posedge rd_clk) cyc++;

  always @(negedge rd_clk) begin
    pop_s <= src_pop;
    if ($countones(src_pop) > 1) multi_pop++;
    if (m_valid && m_ready) begin
      obs_src.push_back(m_src);
      obs_data.push_back(m_data);
      obs_cyc.push_back(cyc);
    end
    if (burst_done) bd_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic data_t mk(input int s, input int k);
    return {4'(s), 12'(k)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    for (int s = 0; s < N_SRC; s++) src_q[s].delete();
  endtask

  task automatic release_reset();
    tick(2);
    reset = 1'b1;
  endtask

  task automatic fill(input int s, input int n);
    for (int k = 0; k < n; k++) src_q[s].push_back(mk(s, k));
  endtask

  task automatic wait_words(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (obs_data.size() < target && n < budget) begin
      tick(1);
      n++;
    end
    if (obs_data.size() < target) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d words, expected %0d", name, obs_data.size(), target);
    end
  endtask

  task automatic check_word(input string name, input int idx, input int s, input int k);
    checks++;
    if (idx >= obs_data.size()) begin
      errors++;
      $display("FAIL %s word %0d: missing, expected src %0d data %h", name, idx, s, mk(s, k));
    end else if (obs_src[idx] !== SRC_W'(s) || obs_data[idx] !== mk(s, k)) begin
      errors++;
      $display("FAIL %s word %0d: got src %0d data %h, expected src %0d data %h",
               name, idx, obs_src[idx], obs_data[idx], s, mk(s, k));
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    tick(2);
    checks++; if (src_pop !== '0) begin errors++; $display("FAIL reset_src_pop: got %b expected 0", src_pop); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    checks++; if (m_src !== '0) begin errors++; $display("FAIL reset_m_src: got %0d expected 0", m_src); end
    checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_burst_done: got %b expected 0", burst_done); end
  endtask

  task automatic test_round_robin();
    int base, bd0, s, k;
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    cfg_burst_len = LEN_W'(4); m_ready = 1'b1; enable = 1'b1;
    fill(0, 8); fill(1, 4); fill(2, 4); fill(3, 4);
    base = obs_data.size(); bd0 = bd_count;
    release_reset();
    wait_words("rr", base + 20, 300);
    tick(5);
    for (int i = 0; i < 20; i++) begin
      s = order[i / 4];
      k = (i >= 16) ? 4 + (i % 4) : (i % 4);
      check_word("rr", base + i, s, k);
    end
    checks++;
    if (bd_count - bd0 != 5) begin errors++; $display("FAIL rr_bursts: got %0d expected 5", bd_count - bd0); end
    checks++;
    if (obs_data.size() >= base + 4 && obs_cyc[base+3] - obs_cyc[base] != 3) begin
      errors++; $display("FAIL rr_throughput: got %0d cycles for 4 words, expected 3", obs_cyc[base+3] - obs_cyc[base]);
    end
  endtask

  task automatic test_early_flush();
    int base, bd0;
    apply_reset();
    cfg_burst_len = LEN_W'(8); m_ready = 1'b1; enable = 1'b1;
    fill(2, 3);
    base = obs_data.size(); bd0 = bd_count;
    release_reset();
    wait_words("early", base + 3, 100);
    tick(5);
    for (int i = 0; i < 3; i++) check_word("early", base + i, 2, i);
    checks++;
    if (bd_count - bd0 != 1) begin errors++; $display("FAIL early_bursts: got %0d expected 1", bd_count - bd0); end
    src_q[1].push_back(mk(1, 0));
    src_q[3].push_back(mk(3, 0));
    wait_words("early_next", base + 5, 100);
    tick(5);
    check_word("early_next", base + 3, 3, 0);
    check_word("early_next", base + 4, 1, 0);
  endtask

  task automatic test_burst_clamp();
    int base, bd0;
    int cfgs [2] = '{0, 12};
    for (int c = 0; c < 2; c++) begin
      apply_reset();
      cfg_burst_len = LEN_W'(cfgs[c]); m_ready = 1'b1; enable = 1'b1;
      fill(0, 10);
      base = obs_data.size(); bd0 = bd_count;
      release_reset();
      wait_words("clamp", base + 10, 200);
      tick(5);
      checks++;
      if (bd_count - bd0 != 2) begin
        errors++; $display("FAIL clamp_bursts cfg=%0d: got %0d expected 2", cfgs[c], bd_count - bd0);
      end
      checks++;
      if (obs_data.size() >= base + 9 &&
          (obs_cyc[base+7] - obs_cyc[base] != 7 || obs_cyc[base+8] - obs_cyc[base+7] < 2)) begin
        errors++; $display("FAIL clamp_split cfg=%0d: got first-8 span %0d gap %0d, expected 7 and >=2",
                           cfgs[c], obs_cyc[base+7] - obs_cyc[base], obs_cyc[base+8] - obs_cyc[base+7]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base, stall_pops, late_pops;
    data_t held;
    apply_reset();
    cfg_burst_len = LEN_W'(8); m_ready = 1'b1; enable = 1'b1;
    fill(1, 8);
    base = obs_data.size();
    release_reset();
    wait_words("bp_start", base + 2, 50);
    m_ready = 1'b0;
    stall_pops = 0; late_pops = 0; held = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      if (src_pop != '0) stall_pops++;
      if (i >= 2 && src_pop != '0) late_pops++;
      if (i == 9) held = m_data;
    end
    checks++;
    if (stall_pops > 2) begin errors++; $display("FAIL bp_buffered: got %0d pops while stalled, expected <=2", stall_pops); end
    checks++;
    if (late_pops != 0) begin errors++; $display("FAIL bp_pop_idle: got %0d late pops, expected 0", late_pops); end
    checks++;
    if (held !== mk(1, 2) || m_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got data %h valid %b, expected %h valid 1", held, m_valid, mk(1, 2));
    end
    @(posedge rd_clk); #1;
    m_ready = 1'b1;
    wait_words("bp_drain", base + 8, 100);
    tick(3);
    for (int i = 0; i < 8; i++) check_word("bp", base + i, 1, i);
  endtask

  task automatic test_enable_drop();
    int base, bd0, n, extra;
    apply_reset();
    cfg_burst_len = LEN_W'(8); m_ready = 1'b1; enable = 1'b1;
    fill(0, 8);
    base = obs_data.size(); bd0 = bd_count;
    release_reset();
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge rd_clk);
      if (src_pop != '0) n++;
    end
    @(posedge rd_clk); #1;
    enable = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      if (src_pop != '0) extra++;
    end
    tick(3);
    checks++;
    if (n != 2 || extra != 0) begin errors++; $display("FAIL en_pops: got %0d+%0d pops, expected 2+0", n, extra); end
    checks++;
    if (obs_data.size() - base != 2) begin errors++; $display("FAIL en_count: got %0d words expected 2", obs_data.size() - base); end
    check_word("en", base, 0, 0);
    check_word("en", base + 1, 0, 1);
    checks++;
    if (bd_count - bd0 != 1) begin errors++; $display("FAIL en_bursts: got %0d expected 1", bd_count - bd0); end
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("FAIL en_state: got %0d expected %0d", dut.state, IDLE); end
  endtask

  task automatic test_reset_inflight();
    int base, n;
    apply_reset();
    cfg_burst_len = LEN_W'(8); m_ready = 1'b0; enable = 1'b1;
    fill(3, 6);
    release_reset();
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge rd_clk);
      if (src_pop != '0) n++;
    end
    @(posedge rd_clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (src_pop !== '0 || m_valid !== 1'b0 || m_data !== '0 || m_src !== '0 || burst_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got pop %b valid %b data %h src %0d done %b, expected all 0",
                         src_pop, m_valid, m_data, m_src, burst_done);
    end
    enable = 1'b0;
    fill(0, 2);
    base = obs_data.size();
    tick(3);
    reset = 1'b1;
    m_ready = 1'b1;
    tick(5);
    checks++;
    if (obs_data.size() != base || m_valid !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: got %0d words valid %b, expected 0 words valid 0", obs_data.size() - base, m_valid);
    end
    enable = 1'b1;
    wait_words("rst_regrant", base + 1, 50);
    check_word("rst_regrant", base, 0, 0);
  endtask

  task automatic test_random();
    int base, total;
    int pushed [N_SRC];
    int got [N_SRC];
    int bad [N_SRC];
    int s;
    apply_reset();
    cfg_burst_len = LEN_W'(3); m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin pushed[i] = 0; got[i] = 0; bad[i] = 0; end
    base = obs_data.size();
    release_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          src_q[i].push_back(mk(i, pushed[i]));
          pushed[i]++;
        end
      end
      m_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    m_ready = 1'b1;
    total = 0;
    for (int i = 0; i < N_SRC; i++) total += pushed[i];
    wait_words("rand", base + total, 3000);
    tick(5);
    for (int i = base; i < obs_data.size(); i++) begin
      s = int'(obs_src[i]);
      if (obs_data[i] !== mk(s, got[s])) bad[s]++;
      got[s]++;
    end
    for (int i = 0; i < N_SRC; i++) begin
      checks++;
      if (got[i] != pushed[i]) begin errors++; $display("FAIL rand_count src%0d: got %0d expected %0d", i, got[i], pushed[i]); end
      checks++;
      if (bad[i] != 0) begin errors++; $display("FAIL rand_order src%0d: got %0d misordered expected 0", i, bad[i]); end
    end
    checks++;
    if (underflows != 0) begin errors++; $display("FAIL pop_when_empty: got %0d expected 0", underflows); end
    checks++;
    if (multi_pop != 0) begin errors++; $display("FAIL pop_onehot: got %0d multi-pop cycles expected 0", multi_pop); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_early_flush();
    test_burst_clamp();
    test_backpressure();
    test_enable_drop();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
